// File: rtl/sseg_scan_driver.sv
// Time-multiplexed seven-segment driver. Scans DIGITS digits over one
// shared segment bus. The displayed value is double buffered so that a
// frame never mixes old and new digits. The driver also provides
// leading-zero blanking, per-digit decimal points, an anti-ghosting blank
// window at the start of each slot, and a one-cycle frame tick.
module sseg_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int BLANK_CYC   = 500,
  parameter bit SEG_ACT_LOW = 1'b0,
  parameter bit AN_ACT_LOW  = 1'b0,
  localparam int IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  load,
  input  logic                  blank_lz,
  output logic [6:0]            sseg,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     an,
  output logic [IDX_W-1:0]      digit_idx,
  output logic                  frame_tick
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

  // Scan position and display buffers
  logic [CNT_W-1:0]    div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] shadow_val_q, shadow_val_d;
  logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [4*DIGITS-1:0] active_val_q, active_val_d;
  logic [DIGITS-1:0]   active_dp_q, active_dp_d;
  logic                slot_end, frame_end;

  // Registered pin drivers
  logic [6:0]          sseg_q, sseg_d;
  logic                dp_out_q, dp_out_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [IDX_W-1:0]    digit_idx_q;
  logic                frame_tick_q;

  // Per-digit views of the active buffer
  logic [3:0]          nib_arr [DIGITS];
  logic [DIGITS-1:0]   nz_vec;   // nibble is non-zero
  logic [DIGITS-1:0]   lz_tail;  // this nibble and every higher one are zero
  logic [DIGITS-1:0]   slot_sel; // one-hot decode of idx_q
  logic                slot_lit; // past the anti-ghosting window
  logic [3:0]          cur_nib;
  logic [6:0]          seg_raw;
  logic                seg_blank;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign nib_arr[gi]  = active_val_q[4*gi +: 4];
    assign nz_vec[gi]   = |active_val_q[4*gi +: 4];
    assign lz_tail[gi]  = ~|nz_vec[DIGITS-1:gi];
    assign slot_sel[gi] = (idx_q == IDX_W'(gi));
  end

  if (BLANK_CYC > 0) begin : g_blank
    assign slot_lit = (div_cnt_q >= BLANK_LIM);
  end else begin : g_no_blank
    assign slot_lit = 1'b1;
  end

  // Next scan position, and the shadow-to-active transfer at the frame boundary
  always_comb begin
    slot_end     = (div_cnt_q == CNT_LAST);
    frame_end    = slot_end && (idx_q == IDX_LAST);
    div_cnt_d    = slot_end ? '0 : div_cnt_q + CNT_W'(1);
    idx_d        = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
    shadow_val_d = load ? value : shadow_val_q;
    shadow_dp_d  = load ? dp : shadow_dp_q;
    active_val_d = active_val_q;
    active_dp_d  = active_dp_q;
    if (frame_end) begin
      // A load that lands on the boundary edge goes straight to the display
      active_val_d = load ? value : shadow_val_q;
      active_dp_d  = load ? dp : shadow_dp_q;
    end
  end

  // Segment, decimal point and enable values for the current slot
  always_comb begin
    cur_nib = nib_arr[idx_q];
    case (cur_nib)
      4'h0:    seg_raw = 7'b1111110;
      4'h1:    seg_raw = 7'b0110000;
      4'h2:    seg_raw = 7'b1101101;
      4'h3:    seg_raw = 7'b1111001;
      4'h4:    seg_raw = 7'b0110011;
      4'h5:    seg_raw = 7'b1011011;
      4'h6:    seg_raw = 7'b1011111;
      4'h7:    seg_raw = 7'b1110000;
      4'h8:    seg_raw = 7'b1111111;
      4'h9:    seg_raw = 7'b1111011;
      4'hA:    seg_raw = 7'b1110111;
      4'hB:    seg_raw = 7'b0011111;
      4'hC:    seg_raw = 7'b1001110;
      4'hD:    seg_raw = 7'b0111101;
      4'hE:    seg_raw = 7'b1001111;
      default: seg_raw = 7'b1000111;
    endcase
    // The rightmost digit always shows, so a zero value still reads "0"
    seg_blank = blank_lz && (idx_q != '0) && lz_tail[idx_q];
    sseg_d    = (seg_blank ? 7'b0000000 : seg_raw) ^ {7{SEG_ACT_LOW}};
    dp_out_d  = active_dp_q[idx_q] ^ SEG_ACT_LOW;
    an_d      = (slot_lit ? slot_sel : '0) ^ {DIGITS{AN_ACT_LOW}};
  end

  // Scan counters and value buffers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q    <= '0;
      idx_q        <= '0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      active_val_q <= '0;
      active_dp_q  <= '0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      idx_q        <= idx_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      active_val_q <= active_val_d;
      active_dp_q  <= active_dp_d;
    end
  end

  // Output registers; reset puts every segment and enable in its off state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sseg_q       <= {7{SEG_ACT_LOW}};
      dp_out_q     <= SEG_ACT_LOW;
      an_q         <= {DIGITS{AN_ACT_LOW}};
      digit_idx_q  <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      sseg_q       <= sseg_d;
      dp_out_q     <= dp_out_d;
      an_q         <= an_d;
      digit_idx_q  <= idx_q;
      frame_tick_q <= frame_end;
    end
  end

  assign sseg       = sseg_q;
  assign dp_out     = dp_out_q;
  assign an         = an_q;
  assign digit_idx  = digit_idx_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Scoreboard bench for sseg_scan_driver. Two instances share their inputs:
// u_hi uses active-high pins and u_lo uses active-low pins. Each frame's
// expected slot contents are queued when the value is loaded. They are
// popped and compared while the DUT scans that frame.
module tb_sseg_scan_driver;

  localparam int D  = 4;
  localparam int SD = 8;
  localparam int BC = 2;

  typedef struct packed {
    logic [1:0] idx;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        load;
  logic        blank_lz;

  logic [6:0]  sseg_a, sseg_b;
  logic        dp_out_a, dp_out_b;
  logic [3:0]  an_a, an_b;
  logic [1:0]  digit_idx_a, digit_idx_b;
  logic        frame_tick_a, frame_tick_b;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  exp_t        sb_q [$];

  sseg_scan_driver #(.DIGITS(D), .SCAN_DIV(SD), .BLANK_CYC(BC),
                     .SEG_ACT_LOW(1'b0), .AN_ACT_LOW(1'b0)) u_hi (
    .clk(clk), .rst_n(rst_n), .value(value), .dp(dp), .load(load),
    .blank_lz(blank_lz), .sseg(sseg_a), .dp_out(dp_out_a), .an(an_a),
    .digit_idx(digit_idx_a), .frame_tick(frame_tick_a)
  );

  sseg_scan_driver #(.DIGITS(D), .SCAN_DIV(SD), .BLANK_CYC(BC),
                     .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1)) u_lo (
    .clk(clk), .rst_n(rst_n), .value(value), .dp(dp), .load(load),
    .blank_lz(blank_lz), .sseg(sseg_b), .dp_out(dp_out_b), .an(an_b),
    .digit_idx(digit_idx_b), .frame_tick(frame_tick_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded 500000 time units");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] seg_code(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1111110;  4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;  4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;  4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;  4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;  4'h9: return 7'b1111011;
      4'hA: return 7'b1110111;  4'hB: return 7'b0011111;
      4'hC: return 7'b1001110;  4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;  default: return 7'b1000111;
    endcase
  endfunction

  // Queue what each slot of a frame showing v/d should look like (active-high)
  function automatic void push_frame(input logic [15:0] v, input logic [3:0] d, input logic blz);
    exp_t e;
    logic [15:0] upper;
    for (int s = 0; s < D; s++) begin
      upper = v >> (4 * s);
      e.idx = 2'(s);
      e.an  = 4'b0001 << s;
      e.seg = (blz && s != 0 && upper == 16'h0) ? 7'b0000000 : seg_code(v[4*s +: 4]);
      e.dp  = d[s];
      sb_q.push_back(e);
    end
  endfunction

  // Advance to the clock just after the next frame boundary edge (bounded)
  task automatic wait_tick();
    bit seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      seen = (frame_tick_a === 1'b1);
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL frame_tick_timeout: saw no frame_tick, required one within 80 clocks");
    end
  endtask

  // Step to the lit part of slot s (called right after wait_tick for s=0) and sample both instances
  task automatic sample_slot(input int s, output logic [13:0] obs_a, output logic [13:0] obs_b);
    repeat ((s == 0) ? 5 : 8) @(negedge clk);
    obs_a = {digit_idx_a, an_a, sseg_a, dp_out_a};
    obs_b = {digit_idx_b, an_b, sseg_b, dp_out_b};
  endtask

  task automatic load_value(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp    = d;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_an;
    int pos, sl;
    rst_n = 1'b0; value = '0; dp = '0; load = 1'b0; blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (13) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({an_a, sseg_a, dp_out_a, frame_tick_a, digit_idx_a} !== 15'b0) begin
      n_fail++;
      $display("FAIL reset_hi: an=%b sseg=%b dp=%b ft=%b idx=%0d, required all zero",
               an_a, sseg_a, dp_out_a, frame_tick_a, digit_idx_a);
    end
    n_checks++;
    if ({an_b, sseg_b, dp_out_b, frame_tick_b, digit_idx_b} !== {4'hF, 7'h7F, 1'b1, 1'b0, 2'd0}) begin
      n_fail++;
      $display("FAIL reset_lo: an=%b sseg=%b dp=%b ft=%b idx=%0d, required an=1111 sseg=1111111 dp=1 ft=0 idx=0",
               an_b, sseg_b, dp_out_b, frame_tick_b, digit_idx_b);
    end
    $display("reset asserted mid-scan: an=%b sseg=%b", an_a, sseg_a);
    @(negedge clk);
    rst_n = 1'b1;
    // Edge k after release shows the state that held before edge k
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      pos    = (k - 1) % SD;
      sl     = ((k - 1) / SD) % D;
      exp_an = (pos >= BC) ? (4'b0001 << sl) : 4'b0000;
      n_checks++;
      if ({an_a, digit_idx_a, frame_tick_a, sseg_a} !== {exp_an, 2'(sl), (k % 32) == 0, 7'b1111110}) begin
        n_fail++;
        $display("FAIL reset_scan edge %0d: an=%b idx=%0d ft=%b sseg=%b, required an=%b idx=%0d ft=%b sseg=1111110",
                 k, an_a, digit_idx_a, frame_tick_a, sseg_a, exp_an, sl, (k % 32) == 0);
      end
    end
    $display("post-reset scan of 33 edges checked");
  endtask

  task automatic test_decode();
    logic [15:0] vals [4];
    logic [13:0] oa, ob;
    exp_t e;
    vals = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
    blank_lz = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_tick();
      load_value(vals[i], 4'(i + 1));
      push_frame(vals[i], 4'(i + 1), 1'b0);
      wait_tick();
      for (int s = 0; s < D; s++) begin
        sample_slot(s, oa, ob);
        e = sb_q.pop_front();
        n_checks++;
        if (oa !== e) begin
          n_fail++;
          $display("FAIL decode %h slot %0d: {idx,an,seg,dp}=%b, required %b", vals[i], s, oa, e);
        end
        $display("decode %h slot %0d an=%b seg=%b dp=%b", vals[i], s, oa[11:8], oa[7:1], oa[0]);
      end
    end
  endtask

  task automatic test_double_buffer();
    logic [13:0] oa, ob;
    exp_t e;
    blank_lz = 1'b0;
    wait_tick();
    load_value(16'h1111, 4'b0001);
    repeat (2) @(negedge clk);
    load_value(16'h2222, 4'b0010);
    push_frame(16'h2222, 4'b0010, 1'b0);
    push_frame(16'h2222, 4'b0010, 1'b0);
    for (int f = 0; f < 2; f++) begin
      wait_tick();
      for (int s = 0; s < D; s++) begin
        sample_slot(s, oa, ob);
        e = sb_q.pop_front();
        n_checks++;
        if (oa !== e) begin
          n_fail++;
          $display("FAIL double_buffer frame %0d slot %0d: {idx,an,seg,dp}=%b, required %b", f, s, oa, e);
        end
        $display("double_buffer frame %0d slot %0d seg=%b", f, s, oa[7:1]);
      end
    end
  endtask

  task automatic test_boundary_load();
    logic [13:0] oa, ob;
    exp_t e;
    blank_lz = 1'b0;
    wait_tick();
    push_frame(16'h7D3C, 4'b1001, 1'b0);
    push_frame(16'h7D3C, 4'b1001, 1'b0);
    repeat (31) @(negedge clk);
    value = 16'h7D3C;
    dp    = 4'b1001;
    load  = 1'b1;
    for (int f = 0; f < 2; f++) begin
      wait_tick();
      load = 1'b0;
      for (int s = 0; s < D; s++) begin
        sample_slot(s, oa, ob);
        e = sb_q.pop_front();
        n_checks++;
        if (oa !== e) begin
          n_fail++;
          $display("FAIL boundary_load frame %0d slot %0d: {idx,an,seg,dp}=%b, required %b", f, s, oa, e);
        end
        $display("boundary_load frame %0d slot %0d seg=%b dp=%b", f, s, oa[7:1], oa[0]);
      end
    end
  endtask

  task automatic test_leading_zero();
    logic [15:0] vals [3];
    logic        blzs [3];
    logic [13:0] oa, ob;
    exp_t e;
    vals = '{16'h0050, 16'h0000, 16'h0000};
    blzs = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      wait_tick();
      blank_lz = blzs[i];
      load_value(vals[i], 4'b0000);
      push_frame(vals[i], 4'b0000, blzs[i]);
      wait_tick();
      for (int s = 0; s < D; s++) begin
        sample_slot(s, oa, ob);
        e = sb_q.pop_front();
        n_checks++;
        if (oa !== e) begin
          n_fail++;
          $display("FAIL leading_zero %h blz=%b slot %0d: {idx,an,seg,dp}=%b, required %b",
                   vals[i], blzs[i], s, oa, e);
        end
        $display("leading_zero %h blz=%b slot %0d seg=%b", vals[i], blzs[i], s, oa[7:1]);
      end
    end
  endtask

  task automatic test_dp();
    logic [13:0] oa, ob;
    exp_t e;
    wait_tick();
    blank_lz = 1'b1;
    load_value(16'h0000, 4'b0100);
    push_frame(16'h0000, 4'b0100, 1'b1);
    wait_tick();
    for (int s = 0; s < D; s++) begin
      sample_slot(s, oa, ob);
      e = sb_q.pop_front();
      n_checks++;
      if (oa !== e) begin
        n_fail++;
        $display("FAIL decimal_point slot %0d: {idx,an,seg,dp}=%b, required %b", s, oa, e);
      end
      $display("decimal_point slot %0d seg=%b dp=%b", s, oa[7:1], oa[0]);
    end
  endtask

  task automatic test_polarity();
    logic [13:0] oa, ob, exp_b;
    exp_t e;
    int hi_a, hi_b;
    logic last_a, last_b;
    wait_tick();
    blank_lz = 1'b0;
    load_value(16'h8888, 4'b0000);
    push_frame(16'h8888, 4'b0000, 1'b0);
    wait_tick();
    for (int s = 0; s < D; s++) begin
      sample_slot(s, oa, ob);
      e = sb_q.pop_front();
      exp_b = {e.idx, e.an ^ 4'hF, e.seg ^ 7'h7F, ~e.dp};
      n_checks++;
      if (ob !== exp_b) begin
        n_fail++;
        $display("FAIL polarity slot %0d: {idx,an,seg,dp}=%b, required %b", s, ob, exp_b);
      end
      $display("polarity slot %0d an=%b seg=%b dp=%b", s, ob[11:8], ob[7:1], ob[0]);
    end
    // Frame tick: exactly one pulse in the next 32 clocks, landing on the 32nd
    wait_tick();
    hi_a = 0; hi_b = 0; last_a = 1'b0; last_b = 1'b0;
    for (int i = 1; i <= D * SD; i++) begin
      @(negedge clk);
      if (frame_tick_a === 1'b1) hi_a++;
      if (frame_tick_b === 1'b1) hi_b++;
      if (i == D * SD) begin
        last_a = frame_tick_a;
        last_b = frame_tick_b;
      end
    end
    n_checks++;
    if (hi_a != 1 || last_a !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_period_hi: %0d pulses, last=%b, required 1 pulse on clock 32", hi_a, last_a);
    end
    n_checks++;
    if (hi_b != 1 || last_b !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_period_lo: %0d pulses, last=%b, required 1 pulse on clock 32", hi_b, last_b);
    end
    $display("frame period: %0d and %0d pulses in 32 clocks", hi_a, hi_b);
  endtask

  initial begin
    test_reset();
    test_decode();
    test_double_buffer();
    test_boundary_load();
    test_leading_zero();
    test_dp();
    test_polarity();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
